// File: rtl/fpu_seq.sv
// fpu_seq -- multicycle binary32 add/multiply unit for the execute stage.
//
// An operation is launched by a Start pulse while the unit is idle or in its
// Done cycle. Operands and the opcode are captured on that edge. Special
// operands are resolved in UNPACK. Adds go through one ALIGN cycle.
// Multiplies run a MUL_STEPS-long shift-add loop. A shared NORM cycle then
// normalises, truncates and clamps the result.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   Start   launch request (ignored while Busy)
//   FpOp    0 = add, 1 = multiply (captured with Start)
//   SrcA    binary32 operand A (captured with Start)
//   SrcB    binary32 operand B (captured with Start)
//   Busy    operation in flight (UNPACK .. NORM)
//   Done    one-cycle completion pulse
//   Result  registered binary32 result
//   Flags   registered {N, Z, C, V}
module fpu_seq #(
    parameter int MUL_STEPS = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        FpOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic [3:0]  Flags
);
    localparam int          CW   = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, MULSTEP, NORM, DONE} state_t;
    state_t state_q, state_d;

    logic [31:0]       a_q, a_d, b_q, b_d;
    logic              op_q, op_d;
    logic              sign_q, sign_d;
    logic              sub_q, sub_d;
    logic signed [9:0] exp_q, exp_d;
    logic [23:0]       mbig_q, mbig_d, msml_q, msml_d;
    logic [7:0]        shamt_q, shamt_d;
    logic [47:0]       val_q, val_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic [3:0]        flags_q, flags_d;

    // Operand fields; exponent 0 is treated as zero (denormals flushed).
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sa     = a_q[31];
    assign sb     = b_q[31];
    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign ma     = {1'b1, a_q[22:0]};
    assign mb     = {1'b1, b_q[22:0]};
    assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    // Special-case resolution (NaN, Inf, zero operands, exact cancellation).
    logic        spec_hit, spec_nan;
    logic [31:0] spec_res;
    logic [3:0]  spec_flags;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = QNAN;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if (!op_q) begin
            if (a_inf && b_inf)           spec_res = (sa == sb) ? {sa, 8'hFF, 23'd0} : QNAN;
            else if (a_inf)               spec_res = {sa, 8'hFF, 23'd0};
            else if (b_inf)               spec_res = {sb, 8'hFF, 23'd0};
            else if (a_zero && b_zero)    spec_res = {sa & sb, 31'd0};
            else if (a_zero)              spec_res = b_q;
            else if (b_zero)              spec_res = a_q;
            else if ((sa != sb) && (a_q[30:0] == b_q[30:0])) spec_res = 32'd0;
            else                          spec_hit = 1'b0;
        end else begin
            if (a_inf || b_inf)           spec_res = (a_zero || b_zero) ? QNAN : {sa ^ sb, 8'hFF, 23'd0};
            else if (a_zero || b_zero)    spec_res = {sa ^ sb, 31'd0};
            else                          spec_hit = 1'b0;
        end
        spec_nan   = (spec_res == QNAN);
        spec_flags = {~spec_nan & spec_res[31], spec_res[30:0] == 31'd0, 1'b0, spec_nan};
    end

    // Datapath helpers.
    logic        a_ge_b;
    logic [23:0] shifted;
    logic [24:0] sum25;
    logic [24:0] step_sum;
    logic [5:0]  lead;
    logic signed [9:0] exp_n;
    logic [22:0] frac_n;
    logic [31:0] norm_res;
    logic [3:0]  norm_flags;

    assign a_ge_b   = (a_q[30:0] >= b_q[30:0]);
    assign shifted  = (shamt_q >= 8'd26) ? 24'd0 : (msml_q >> shamt_q);
    assign sum25    = sub_q ? ({1'b0, mbig_q} - {1'b0, shifted})
                            : ({1'b0, mbig_q} + {1'b0, shifted});
    // Right-shifting multiplier: low half holds the remaining multiplier bits.
    assign step_sum = {1'b0, val_q[47:24]} + (val_q[0] ? {1'b0, mbig_q} : 25'd0);

    // val_q is scaled so bit 46 is the units bit for both add and multiply.
    always_comb begin
        lead = 6'd0;
        for (int i = 0; i < 48; i++) begin
            if (val_q[i]) lead = 6'(i);
        end
        exp_n  = exp_q + $signed({4'd0, lead}) - 10'sd46;
        frac_n = 23'((val_q << (6'd47 - lead)) >> 24);
        if (val_q == 48'd0) begin
            norm_res   = 32'd0;
            norm_flags = 4'b0100;
        end else if (exp_n >= 10'sd255) begin
            norm_res   = {sign_q, 8'hFF, 23'd0};
            norm_flags = {sign_q, 3'b001};
        end else if (exp_n <= 10'sd0) begin
            norm_res   = {sign_q, 31'd0};
            norm_flags = {sign_q, 3'b100};
        end else begin
            norm_res   = {sign_q, exp_n[7:0], frac_n};
            norm_flags = {sign_q, 3'b000};
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        exp_d    = exp_q;
        mbig_d   = mbig_q;
        msml_d   = msml_q;
        shamt_d  = shamt_q;
        val_d    = val_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Start) begin
                    a_d     = SrcA;
                    b_d     = SrcB;
                    op_d    = FpOp;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                if (spec_hit) begin
                    result_d = spec_res;
                    flags_d  = spec_flags;
                    state_d  = DONE;
                end else if (!op_q) begin
                    sign_d  = a_ge_b ? sa : sb;
                    sub_d   = sa ^ sb;
                    exp_d   = $signed({2'b00, a_ge_b ? ea : eb});
                    mbig_d  = a_ge_b ? ma : mb;
                    msml_d  = a_ge_b ? mb : ma;
                    shamt_d = a_ge_b ? (ea - eb) : (eb - ea);
                    state_d = ALIGN;
                end else begin
                    sign_d  = sa ^ sb;
                    exp_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
                    mbig_d  = ma;
                    val_d   = {24'd0, mb};
                    cnt_d   = '0;
                    state_d = MULSTEP;
                end
            end
            ALIGN: begin
                val_d   = {sum25, 23'd0};
                state_d = NORM;
            end
            MULSTEP: begin
                val_d = {step_sum, val_q[23:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(MUL_STEPS - 1)) state_d = NORM;
            end
            NORM: begin
                result_d = norm_res;
                flags_d  = norm_flags;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            exp_q    <= '0;
            mbig_q   <= '0;
            msml_q   <= '0;
            shamt_q  <= '0;
            val_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            exp_q    <= exp_d;
            mbig_q   <= mbig_d;
            msml_q   <= msml_d;
            shamt_q  <= shamt_d;
            val_q    <= val_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign Busy   = (state_q == UNPACK) || (state_q == ALIGN) ||
                    (state_q == MULSTEP) || (state_q == NORM);
    assign Done   = (state_q == DONE);
    assign Result = result_q;
    assign Flags  = flags_q;
endmodule

// File: tb/tb_fpu_seq.sv
// Testbench for fpu_seq: directed test-plan cases, reset-in-flight,
// back-to-back launch, then random operands against a numeric reference model.
module tb_fpu_seq;
    localparam int          MUL_STEPS = 24;
    localparam logic [31:0] NAN       = 32'h7FC00000;
    localparam int          LIMIT     = 200;
    localparam longint      M23       = 64'sd8388608;
    localparam longint      M24       = 64'sd16777216;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic        FpOp  = 1'b0;
    logic [31:0] SrcA  = 32'd0;
    logic [31:0] SrcB  = 32'd0;
    logic        Busy, Done;
    logic [31:0] Result;
    logic [3:0]  Flags;

    int total = 0;
    int bad   = 0;

    fpu_seq #(.MUL_STEPS(MUL_STEPS)) dut (
        .clk(clk), .reset(reset), .Start(Start), .FpOp(FpOp),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
        .Result(Result), .Flags(Flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s: observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    // Reference model: works on integer significands and exponents directly.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic op,
                                      output logic [31:0] r, output logic [3:0] f, output int lat);
        logic   sa, sb, s, special, ovf, isnan;
        int     ea, eb, e, d;
        longint ma, mb, m, big, sml;
        logic   an, bn, ai, bi, az, bz;
        sa = a[31]; sb = b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        ma = longint'({1'b1, a[22:0]}); mb = longint'({1'b1, b[22:0]});
        an = (ea == 255) && (a[22:0] != 0); bn = (eb == 255) && (b[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0); bi = (eb == 255) && (b[22:0] == 0);
        az = (ea == 0); bz = (eb == 0);
        special = 1'b1; ovf = 1'b0; r = NAN;
        if (an || bn) r = NAN;
        else if (!op) begin
            if (ai && bi)      r = (sa == sb) ? {sa, 8'hFF, 23'd0} : NAN;
            else if (ai)       r = {sa, 8'hFF, 23'd0};
            else if (bi)       r = {sb, 8'hFF, 23'd0};
            else if (az && bz) r = {sa & sb, 31'd0};
            else if (az)       r = b;
            else if (bz)       r = a;
            else if (sa != sb && a[30:0] == b[30:0]) r = 32'd0;
            else special = 1'b0;
        end else begin
            if (ai || bi)      r = (az || bz) ? NAN : {sa ^ sb, 8'hFF, 23'd0};
            else if (az || bz) r = {sa ^ sb, 31'd0};
            else special = 1'b0;
        end
        if (!special) begin
            if (!op) begin
                if (a[30:0] >= b[30:0]) begin
                    big = ma; sml = mb; e = ea; d = ea - eb; s = sa;
                end else begin
                    big = mb; sml = ma; e = eb; d = eb - ea; s = sb;
                end
                if (d >= 26) sml = 0; else sml = sml >> d;
                m = (sa == sb) ? big + sml : big - sml;
            end else begin
                m = (ma * mb) >> 23;
                e = ea + eb - 127;
                s = sa ^ sb;
            end
            while (m >= M24) begin m = m >> 1; e++; end
            while (m != 0 && m < M23) begin m = m << 1; e--; end
            if (m == 0)        r = 32'd0;
            else if (e >= 255) begin r = {s, 8'hFF, 23'd0}; ovf = 1'b1; end
            else if (e <= 0)   r = {s, 31'd0};
            else               r = {s, 8'(e), 23'(m)};
        end
        isnan = (r == NAN);
        f   = {~isnan & r[31], r[30:0] == 31'd0, 1'b0, isnan | ovf};
        lat = special ? 2 : (op ? MUL_STEPS + 3 : 4);
    endfunction

    function automatic logic [31:0] rand_operand();
        logic        s;
        logic [22:0] fr;
        int          k;
        s  = 1'($urandom_range(0, 1));
        fr = 23'($urandom);
        k  = int'($urandom_range(0, 11));
        case (k)
            0:       return {s, 8'h00, 23'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, fr | 23'd1};
            3:       return {s, 8'h00, fr | 23'd1};
            4:       return {s, 8'($urandom_range(200, 254)), fr};
            5:       return {s, 8'($urandom_range(1, 40)), fr};
            default: return {s, 8'($urandom_range(100, 154)), fr};
        endcase
    endfunction

    // Called at #1 after the accepting edge; returns cycles until Done (lat).
    task automatic wait_done(input int poke, output int lat, output int busy_n);
        lat = 1; busy_n = 0;
        while (!Done && lat < LIMIT) begin
            if (Busy) busy_n++;
            if (lat == poke) begin
                Start = 1'b1; SrcA = $urandom; SrcB = $urandom; FpOp = ~FpOp;
            end else if (lat == poke + 1) begin
                Start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] er, input logic [3:0] ef,
                         input int elat, input int poke);
        int lat, busy_n;
        @(negedge clk);
        Start = 1'b1; FpOp = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        Start = 1'b0; SrcA = $urandom; SrcB = $urandom; FpOp = ~op;
        wait_done(poke, lat, busy_n);
        check(tag, "latency", 32'(lat), 32'(elat));
        check(tag, "busy_cycles", 32'(busy_n), 32'(elat - 1));
        check(tag, "busy_in_done", 32'(Busy), 32'd0);
        check(tag, "result", Result, er);
        check(tag, "flags", 32'(Flags), 32'(ef));
        $display("op %s: %h %s %h -> %h flags=%b lat=%0d", tag, a, op ? "*" : "+", b,
                 Result, Flags, lat);
        @(posedge clk); #1;
        check(tag, "done_width", 32'(Done), 32'd0);
        check(tag, "result_held", Result, er);
    endtask

    initial begin
        int lat, busy_n, done_seen;

        // Reset state
        #3 reset = 1'b1;
        @(posedge clk); #1;
        check("reset", "busy", 32'(Busy), 32'd0);
        check("reset", "done", 32'(Done), 32'd0);
        check("reset", "result", Result, 32'd0);
        check("reset", "flags", 32'(Flags), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed test-plan cases
        do_op("add_1_2",     32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 4, -100);
        do_op("mul_poke",    32'h3FC00000, 32'h40200000, 1'b1, 32'h40700000, 4'b0000, 27, 10);
        do_op("cancel",      32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0100, 2, -100);
        do_op("truncate",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000, 4, -100);
        do_op("overflow",    32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F800000, 4'b0001, 27, -100);
        do_op("zero_x_inf",  32'h00000000, 32'h7F800000, 1'b1, NAN,          4'b0001, 2, -100);
        do_op("neg_denorm",  32'hC0400000, 32'h00000001, 1'b0, 32'hC0400000, 4'b1000, 2, -100);

        // Reset asserted at cycle 10 of a multiply
        @(negedge clk);
        Start = 1'b1; FpOp = 1'b1; SrcA = 32'h3FC00000; SrcB = 32'h40200000;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("mid_reset", "busy_before", 32'(Busy), 32'd1);
        reset = 1'b1; #1;
        check("mid_reset", "busy", 32'(Busy), 32'd0);
        check("mid_reset", "done", 32'(Done), 32'd0);
        check("mid_reset", "result", Result, 32'd0);
        check("mid_reset", "flags", 32'(Flags), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        done_seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (Done || Busy) done_seen++;
        end
        check("mid_reset", "no_activity_after", 32'(done_seen), 32'd0);
        $display("op mid_reset: multiply aborted at cycle 10");

        // Back-to-back: Start held through the add's Done cycle
        @(negedge clk);
        Start = 1'b1; FpOp = 1'b0; SrcA = 32'h40000000; SrcB = 32'h40000000;
        @(posedge clk); #1;
        FpOp = 1'b1; SrcA = 32'h3FC00000; SrcB = 32'h40200000;
        wait_done(-100, lat, busy_n);
        check("b2b_add", "latency", 32'(lat), 32'd4);
        check("b2b_add", "result", Result, 32'h40800000);
        check("b2b_add", "flags", 32'(Flags), 32'd0);
        $display("op b2b_add: 40000000 + 40000000 -> %h lat=%0d", Result, lat);
        @(posedge clk); #1;
        Start = 1'b0;
        check("b2b_mul", "busy_no_gap", 32'(Busy), 32'd1);
        check("b2b_mul", "done_low", 32'(Done), 32'd0);
        wait_done(-100, lat, busy_n);
        check("b2b_mul", "latency", 32'(lat), 32'd27);
        check("b2b_mul", "result", Result, 32'h40700000);
        $display("op b2b_mul: 3FC00000 * 40200000 -> %h lat=%0d", Result, lat);
        @(posedge clk); #1;

        // Random operands against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b, er;
            logic [3:0]  ef;
            logic        op;
            int          elat;
            a = rand_operand();
            b = rand_operand();
            case ($urandom_range(0, 5))
                0:       b = a ^ 32'h80000000;
                1:       b = {~a[31], a[30:23], 23'($urandom)};
                default: ;
            endcase
            op = 1'($urandom_range(0, 1));
            ref_model(a, b, op, er, ef, elat);
            do_op("rand", a, b, op, er, ef, elat, -100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
